// File: rtl/delay_pkg.sv
// delay_pkg: sizing helpers shared by the delay-line family (delay, elastic_delay).
package delay_pkg;
   // Occupancy counter width: enough for 0..cycles, never narrower than 1 bit.
   function automatic int cnt_w(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction
endpackage

// File: rtl/elastic_stage.sv
// elastic_stage: one valid/data slot of a bubble-collapsing pipeline.
module elastic_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_up_valid,
   input  logic [WIDTH-1:0] i_up_data,
   input  logic             i_dn_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic             o_ready
);
   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   // An empty slot can always load, so bubbles are squeezed out during a stall.
   assign o_ready = i_dn_ready | ~r_valid;
   assign o_valid = r_valid;
   assign o_data  = r_data;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (o_ready) begin
         r_valid <= i_up_valid;
         if (i_up_valid) r_data <= i_up_data;
      end
   end
endmodule

// File: rtl/elastic_delay.sv
// elastic_delay: CYCLES-deep valid/ready delay line whose empty stages collapse
// under backpressure; CYCLES = 0 degenerates to plain wiring.
module elastic_delay
   import delay_pkg::*;
#(
   parameter int CYCLES = 4,
   parameter int WIDTH  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [cnt_w(CYCLES)-1:0]  count
);
   localparam int CW = cnt_w(CYCLES);
   generate
      if (CYCLES == 0) begin : g_wire
         assign out_valid = in_valid;
         assign out_data  = in_data;
         assign in_ready  = out_ready;
         assign count     = '0;
      end else begin : g_pipe
         logic [CYCLES:0]   w_v;
         logic [WIDTH-1:0]  w_d [0:CYCLES];
         logic [CYCLES+1:1] w_r;
         logic              w_in_fire;
         logic              w_out_fire;
         logic [CW-1:0]     r_count;
         // Index 0 is the producer side; the ready chain ripples from out_ready back to S1.
         assign w_v[0]         = in_valid & w_r[1];
         assign w_d[0]         = in_data;
         assign w_r[CYCLES+1]  = out_ready;
         for (genvar i = 1; i <= CYCLES; i++) begin : g_stage
            elastic_stage #(.WIDTH(WIDTH)) u_stage (
               .clk        (clk),
               .rst        (rst),
               .i_up_valid (w_v[i-1]),
               .i_up_data  (w_d[i-1]),
               .i_dn_ready (w_r[i+1]),
               .o_valid    (w_v[i]),
               .o_data     (w_d[i]),
               .o_ready    (w_r[i])
            );
         end
         assign w_in_fire  = w_v[0];
         assign w_out_fire = w_v[CYCLES] & out_ready;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) r_count <= '0;
            else if (w_in_fire != w_out_fire) r_count <= w_in_fire ? r_count + 1'b1 : r_count - 1'b1;
         end
         assign in_ready  = w_r[1];
         assign out_valid = w_v[CYCLES];
         assign out_data  = w_d[CYCLES];
         assign count     = r_count;
      end
   endgenerate
endmodule
